// File: rtl/ddr_model_pkg.sv
// Shared types and helpers for the external-memory read channel model.
package ddr_model_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int unsigned FEAT_W   = 128;
  localparam int unsigned WEIGHT_W = 64;
  localparam int unsigned INSTR_W  = 64;

  // Bits needed to index v entries; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ddr_rsp_fifo.sv
// First-word-fall-through synchronous FIFO; depth need not be a power of 2.
module ddr_rsp_fifo
  import ddr_model_pkg::*;
#(
  parameter int unsigned W     = 129,
  parameter int unsigned D     = 5,
  parameter int unsigned CNT_W = clog2(D + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = clog2(D);

  logic [W-1:0]     mem [D];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(D));
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(D - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= (rd_ptr == PTR_W'(D - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Upstream credit accounting must never let a push land on a full buffer.
  always_ff @(posedge clk) begin
    if (!rst && push) assert (!full);
  end

endmodule

// File: rtl/ddr_port_model.sv
// One external-memory read channel: preload write port, burst reads with
// fixed read latency, credit-controlled response buffer.
module ddr_port_model
  import ddr_model_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 3,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned FIFO_D = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              err_oob
);

  localparam int unsigned IDX_W = clog2(DEPTH);
  localparam int unsigned CNT_W = clog2(FIFO_D + 1);
  localparam int unsigned ENT_W = DATA_W + 1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W:0]    remaining;
  logic              accept, issue, issue_last, credit;
  logic              rd_oob, wr_oob, pipe_any;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              push;
  logic [ENT_W-1:0]  push_ent, head;
  logic [CNT_W-1:0]  fifo_cnt, inflight;
  logic              fifo_full, fifo_empty;

  assign wr_oob     = 32'(wr_addr) >= DEPTH;
  assign rd_oob     = 32'(cur_addr) >= DEPTH;
  assign rd_word    = rd_oob ? '0 : mem[IDX_W'(cur_addr)];
  assign issue_last = (remaining == (LEN_W + 1)'(1));
  assign credit     = !fifo_full && ((32'(fifo_cnt) + 32'(inflight)) < FIFO_D);

  // Nonblocking write gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_oob) mem[IDX_W'(wr_addr)] <= wr_data;
  end

  assign req_ready = !rst && (state == IDLE) && fifo_empty && !pipe_any;
  assign busy      = (state != IDLE) || pipe_any || !fifo_empty;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (credit) begin
          issue = 1'b1;
          if (issue_last) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!pipe_any && fifo_empty) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      err_oob   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cur_addr  <= req_addr;
        remaining <= (LEN_W + 1)'(req_len) + (LEN_W + 1)'(1);
      end else if (issue) begin
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - (LEN_W + 1)'(1);
      end
      if ((issue && rd_oob) || (wr_en && wr_oob)) err_oob <= 1'b1;
    end
  end

  // Read pipeline: RD_LAT-1 register stages, the FIFO write is the last one.
  if (RD_LAT == 1) begin : g_lat1
    assign push     = issue;
    assign push_ent = {issue_last, rd_word};
    assign pipe_any = 1'b0;
    assign inflight = '0;
  end else begin : g_pipe
    localparam int unsigned NS = RD_LAT - 1;
    logic [NS-1:0]    pv;
    logic [ENT_W-1:0] pd [NS];

    always_ff @(posedge clk) begin
      if (rst) begin
        pv <= '0;
      end else begin
        pv[0] <= issue;
        for (int k = 1; k < NS; k++) pv[k] <= pv[k-1];
      end
    end

    always_ff @(posedge clk) begin
      pd[0] <= {issue_last, rd_word};
      for (int k = 1; k < NS; k++) pd[k] <= pd[k-1];
    end

    always_comb begin
      inflight = '0;
      for (int k = 0; k < NS; k++) inflight = inflight + CNT_W'(pv[k]);
    end

    assign push     = pv[NS-1];
    assign push_ent = pd[NS-1];
    assign pipe_any = |pv;
  end

  ddr_rsp_fifo #(
    .W    (ENT_W),
    .D    (FIFO_D),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_ent),
    .pop      (rsp_ready),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_empty ? '0 : head[DATA_W-1:0];
  assign rsp_last  = !fifo_empty && head[DATA_W];

endmodule

// File: doc/ddr_port_model.md
Name: ddr_port_model

Overview:
- Parametrised, synthesizable model of one external-memory read channel. Replaces the zero-latency combinational storage arrays used by the feature, weight and instruction benches.
- Adds a preload write port and burst read requests, with configurable read latency, valid/ready handshake and a response buffer.
- Instantiated once per channel (feature, weight, instr) around `top`; usable on FPGA as a DDR stand-in.

Parameters:
- DATA_W, 128: data word width in bits.
- ADDR_W, 16: address width.
- DEPTH, 1024: number of words; need not be a power of 2.
- RD_LAT, 3: cycles from array read issue to data at buffer input (>=1).
- LEN_W, 8: burst length field width; beats = req_len+1.
- FIFO_D, RD_LAT+2: response buffer depth.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- wr_en, in, 1: preload write strobe.
- wr_addr, in, ADDR_W: preload address.
- wr_data, in, DATA_W: preload data.
- req_valid, in, 1: burst request valid.
- req_ready, out, 1: request accepted when req_valid && req_ready.
- req_addr, in, ADDR_W: burst start address.
- req_len, in, LEN_W: burst beats minus 1.
- rsp_valid, out, 1: response beat valid.
- rsp_ready, in, 1: consumer ready.
- rsp_data, out, DATA_W: response data.
- rsp_last, out, 1: final beat of burst.
- busy, out, 1: burst in progress, or beats in pipeline/buffer.
- err_oob, out, 1: sticky, set on any access with addr>=DEPTH.

Behaviour:
- Reset: req_ready=0, rsp_valid=0, rsp_last=0, busy=0, err_oob=0, rsp_data=0. FSM goes to IDLE; pipeline valid bits and FIFO pointers are cleared; array contents are retained.
- Reset mid-burst: all in-flight beats are dropped. No rsp_valid in the cycle after rst falls.
- FSM IDLE:
  - req_ready=1 only if the FIFO is empty and no pipeline stage is valid.
  - On handshake: latch cur_addr=req_addr, remaining=req_len+1, go to ISSUE. req_ready=0 the next cycle.
- FSM ISSUE:
  - Each cycle, issue one array read at cur_addr when credit is available. Credit = FIFO free entries minus in-flight reads > 0.
  - Each issue: cur_addr increments, remaining decrements. The issue with remaining==1 tags the beat last and goes to DRAIN.
- FSM DRAIN: when pipeline and FIFO are both empty, go to IDLE. req_ready rises the following cycle.
- Latency: data from an issue at cycle t enters the FIFO at t+RD_LAT.
- FIFO is first-word-fall-through: rsp_valid=!empty, rsp_data/rsp_last = head entry. A beat transfers when rsp_valid && rsp_ready.
- Minimum request-to-first-beat latency: 1 (accept) + RD_LAT cycles.
- Throughput: with rsp_ready held high, one beat per cycle and no bubbles.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data and rsp_last hold stable. The credit rule guarantees no FIFO overflow; a push to a full FIFO is a design error and is checked by assertion.
- Address wrap: cur_addr wraps to 0 after 2^ADDR_W-1.
- Out of bounds: an issue with cur_addr>=DEPTH returns 0 for that beat and sets err_oob. A write with wr_addr>=DEPTH is ignored and sets err_oob. err_oob clears only on rst.
- Write/read collision, same address, same cycle: read-first, i.e. the old data is returned.
- Writes are accepted in any state and are not blocked by bursts.
- busy = (state!=IDLE) || pipeline valid || !fifo_empty.

Decomposition:
- Package ddr_model_pkg holds:
  - FSM state enum (IDLE, ISSUE, DRAIN).
  - clog2 helper function.
  - Default width constants: FEAT_W=128, WEIGHT_W=64, INSTR_W=64.
- Sub-module ddr_rsp_fifo: parametrised FWFT synchronous FIFO.
  - Ports: width DATA_W+1, depth FIFO_D; push, pop, full, empty, count.
  - Count output is used for credit.
- Read pipeline, FSM and array live in ddr_port_model.

Test Plan:
- Preload words 0..15 with value=addr*3 via wr_en; request addr=4, len=3, rsp_ready=1 → 4 beats 12,15,18,21 on consecutive cycles. First beat 1+RD_LAT=4 cycles after accept; rsp_last only on beat 21; then req_ready=1.
- Same burst with rsp_ready toggling 1,0,0,1,... → identical data order, no loss or duplication. rsp_data stable while stalled; FIFO never exceeds FIFO_D.
- DEPTH=1000, request addr=998, len=3 → beats mem[998], mem[999], 0, 0. err_oob=1 from the first OOB issue and stays 1 until rst.
- Assert rst for 1 cycle at the second beat of a len=7 burst → rsp_valid=0 and busy=0 after reset. A new request addr=0, len=0 returns exactly mem[0] with rsp_last=1.
- Write addr=5 to 0xAA in the same cycle the burst issues addr=5 (old value 0x0F) → beat returns 0x0F. A later read of addr 5 returns 0xAA.
- Request with req_len=255 at RD_LAT=1 and RD_LAT=5 → 256 beats, back-to-back under rsp_ready=1, rsp_last on the 256th only.
